// File: rtl/calc.sv
// 16-bit accumulator calculator: button-selected ALU operation between the
// accumulator and the switch operand, committed on btnd, cleared on btnu.
module calc (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  logic [15:0]        acc_r;
  logic [15:0]        result_s;
  logic [3:0]         shamt_s;
  logic signed [15:0] acc_signed_s;
  op_e                op_s;

  // Decode the three operation buttons into the internal op code.
  always_comb begin
    op_s = OP_ADD;
    case ({btnl, btnc, btnr})
      3'b000:  op_s = OP_ADD;
      3'b001:  op_s = OP_SUB;
      3'b010:  op_s = OP_AND;
      3'b011:  op_s = OP_OR;
      3'b100:  op_s = OP_XOR;
      3'b101:  op_s = OP_SLL;
      3'b110:  op_s = OP_SRL;
      3'b111:  op_s = OP_SRA;
      default: op_s = OP_ADD;
    endcase
  end

  // Shifts only look at the low nibble of the operand.
  assign shamt_s      = sw[3:0];
  assign acc_signed_s = $signed(acc_r);

  // Combinational 16-bit ALU; arithmetic wraps modulo 2^16.
  always_comb begin
    result_s = acc_r;
    case (op_s)
      OP_ADD:  result_s = acc_r + sw;
      OP_SUB:  result_s = acc_r - sw;
      OP_AND:  result_s = acc_r & sw;
      OP_OR:   result_s = acc_r | sw;
      OP_XOR:  result_s = acc_r ^ sw;
      OP_SLL:  result_s = acc_r << shamt_s;
      OP_SRL:  result_s = acc_r >> shamt_s;
      OP_SRA:  result_s = $unsigned(acc_signed_s >>> shamt_s);
      default: result_s = acc_r;
    endcase
  end

  // Accumulator register: clear wins over commit, otherwise hold.
  always_ff @(posedge clk) begin
    if (btnu) begin
      acc_r <= 16'h0000;
    end else if (btnd) begin
      acc_r <= result_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign led = acc_r;

endmodule

// File: tb/tb_calc.sv
// Directed self-checking bench for calc; expected values are hand-computed.
module tb_calc;

  logic        clk;
  logic        btnu;
  logic        btnd;
  logic        btnl;
  logic        btnc;
  logic        btnr;
  logic [15:0] sw;
  logic [15:0] led;

  int n_compared;
  int n_mismatched;

  calc dut (
    .clk  (clk),
    .btnu (btnu),
    .btnd (btnd),
    .btnl (btnl),
    .btnc (btnc),
    .btnr (btnr),
    .sw   (sw),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Apply one operation for exactly one rising edge, then check led.
  task automatic commit(input logic [2:0] op, input logic [15:0] operand,
                        input logic [15:0] exp, input string tag);
    @(negedge clk);
    {btnl, btnc, btnr} = op;
    sw   = operand;
    btnd = 1'b1;
    @(posedge clk);
    #1;
    btnd = 1'b0;
    check_val(tag, led, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btnu = 1'b1;
    btnd = 1'b0;
    @(posedge clk);
    #1;
    btnu = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    btnu = 1'b1;
    btnd = 1'b1;
    {btnl, btnc, btnr} = 3'b000;
    sw = 16'h1234;

    // Reset held two clocks with commit high.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("reset", led, 16'h0000);
    btnu = 1'b0;
    btnd = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("reset_hold", led, 16'h0000);

    // Chained operations from zero.
    commit(3'b000, 16'h1234, 16'h1234, "add");
    commit(3'b001, 16'h0FF0, 16'h0244, "sub");
    commit(3'b010, 16'h324F, 16'h0244, "and");
    commit(3'b011, 16'h2D31, 16'h2F75, "or");
    commit(3'b100, 16'hFFFF, 16'hD08A, "xor");

    // Shifts; upper operand bits must be ignored.
    commit(3'b101, 16'h0004, 16'h08A0, "sll4");
    commit(3'b110, 16'h0004, 16'h008A, "srl4");
    commit(3'b110, 16'hFFF0, 16'h008A, "srl0");
    do_reset();
    commit(3'b000, 16'h8000, 16'h8000, "load8000");
    commit(3'b111, 16'h0004, 16'hF800, "sra4");
    commit(3'b111, 16'hFFF0, 16'hF800, "sra0");
    commit(3'b111, 16'h000F, 16'hFFFF, "sra15");
    commit(3'b110, 16'h001F, 16'h0001, "srl15");
    commit(3'b101, 16'h000F, 16'h8000, "sll15");

    // Wrap-around in both directions.
    do_reset();
    commit(3'b001, 16'h0001, 16'hFFFF, "sub_wrap");
    commit(3'b000, 16'h0001, 16'h0000, "add_wrap");

    // Enable gating: op and sw toggle while btnd is low.
    commit(3'b000, 16'h00A5, 16'h00A5, "load_a5");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {btnl, btnc, btnr} = 3'(i);
      sw = 16'hFFFF ^ 16'(i * 16'h1357);
      @(posedge clk);
      #1;
      check_val("gate_hold", led, 16'h00A5);
    end

    // btnd held for three edges re-applies the add.
    do_reset();
    @(negedge clk);
    {btnl, btnc, btnr} = 3'b000;
    sw   = 16'h0001;
    btnd = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check_val("held_add", led, 16'(i));
    end
    btnd = 1'b0;
    @(posedge clk);
    #1;
    check_val("held_release", led, 16'h0003);

    // Reset wins over commit.
    @(negedge clk);
    btnu = 1'b1;
    btnd = 1'b1;
    {btnl, btnc, btnr} = 3'b000;
    sw = 16'h1111;
    @(posedge clk);
    #1;
    btnu = 1'b0;
    btnd = 1'b0;
    check_val("reset_prio", led, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
